// File: rtl/u13_pkg.sv
// u13_pkg: shared constants and types for the u13 memory/bus subsystem.
//   NOP          : opcode returned for unmapped and port reads
//   RST_ADDR_DEF : default core reset vector, which is also the ROM base
//   IO_ADDR_DEF  : default output port address (zero page)
//   TICK_OFS     : offset of the tick counter from the port address
//   state_t      : load sequencer states
package u13_pkg;

  localparam logic [7:0]  NOP          = 8'hea;
  localparam logic [15:0] RST_ADDR_DEF = 16'hfff0;
  localparam logic [15:0] IO_ADDR_DEF  = 16'h0080;
  localparam logic [15:0] TICK_OFS     = 16'h0001;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/u13_ram.sv
// u13_ram: byte-wide storage array with a synchronous write port and an
// asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module u13_ram #(
  parameter int AW     = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/u13_mem.sv
// u13_mem: memory and bus subsystem behind the u13 core.
// Holds zero-page RAM, a loadable program ROM at the reset vector and one
// output port. After reset a byte-stream loader fills the ROM while the core
// is held in reset; the core is then released and served over its bus.
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   addr     : core bus address
//   rw       : core bus direction, 1 = core writes, 0 = core reads
//   data     : core bus data (driven here only on RUN-state reads)
//   cpu_rst  : synchronous active-high reset to the core
//   ld_valid : loader byte valid
//   ld_ready : loader ready (LOAD state only)
//   ld_data  : loader byte
//   ld_last  : final loader byte
//   io_out   : output port value
//   io_stb   : one-cycle pulse per port write
//
// Build option: define U13_MEM_TICK_EN to add a free-running 8-bit RUN-cycle
// counter readable at IO_ADDR+1. Without it that address reads as NOP.
module u13_mem
  import u13_pkg::*;
#(
  parameter int          RAM_AW   = 7,
  parameter int          ROM_AW   = 4,
  parameter logic [15:0] RST_ADDR = RST_ADDR_DEF,
  parameter logic [15:0] IO_ADDR  = IO_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rw,
  inout  wire  [7:0]  data,
  output logic        cpu_rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic [7:0]  io_out,
  output logic        io_stb
);

  state_t            state, state_nxt;
  logic [ROM_AW-1:0] ld_cnt;
  logic              run;
  logic              ld_xfer;
  logic              ld_done;
  logic [15:0]       rom_ofs;
  logic              in_ram;
  logic              in_rom;
  logic              is_io;
  logic              ram_we;
  logic              io_we;
  logic [7:0]        ram_rd;
  logic [7:0]        rom_rd;
  logic [7:0]        rd_val;

  assign run      = (state == ST_RUN);
  assign ld_ready = (state == ST_LOAD);
  assign cpu_rst  = !run;
  assign ld_xfer  = ld_valid & ld_ready;
  // The transfer into the last ROM slot ends the load even without ld_last.
  assign ld_done  = ld_last | (ld_cnt == {ROM_AW{1'b1}});

  // Full 16-bit decode: the ROM offset wraps modulo 2^16, so only the window
  // RST_ADDR..RST_ADDR+2^ROM_AW-1 leaves the upper offset bits clear.
  assign rom_ofs = addr - RST_ADDR;
  assign in_ram  = (addr[15:RAM_AW] == '0);
  assign in_rom  = (rom_ofs[15:ROM_AW] == '0);
  assign is_io   = (addr == IO_ADDR);

  assign ram_we = run & rw & in_ram;
  assign io_we  = run & rw & is_io;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:    if (ld_xfer && ld_done) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_RUN;
      ST_RUN:     state_nxt = ST_RUN;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ld_cnt <= '0;
    else if (ld_xfer) ld_cnt <= ld_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_out <= 8'h00;
      io_stb <= 1'b0;
    end else begin
      io_stb <= io_we;
      if (io_we) io_out <= data;
    end
  end

`ifdef U13_MEM_TICK_EN
  logic [7:0] tick;

  // Held at zero until RUN, so the first RUN cycle reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     tick <= 8'h00;
    else if (run) tick <= tick + 8'd1;
    else          tick <= 8'h00;
  end
`endif

  u13_ram #(.AW(RAM_AW), .DATA_W(8)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr[RAM_AW-1:0]),
    .wdata (data),
    .raddr (addr[RAM_AW-1:0]),
    .rdata (ram_rd)
  );

  u13_ram #(.AW(ROM_AW), .DATA_W(8)) u_rom (
    .clk   (clk),
    .we    (ld_xfer),
    .waddr (ld_cnt),
    .wdata (ld_data),
    .raddr (rom_ofs[ROM_AW-1:0]),
    .rdata (rom_rd)
  );

  // Anything not backed by storage reads as NOP so stray fetches are harmless.
  always_comb begin
    rd_val = NOP;
    if (in_ram)      rd_val = ram_rd;
    else if (in_rom) rd_val = rom_rd;
`ifdef U13_MEM_TICK_EN
    else if (addr == IO_ADDR + TICK_OFS) rd_val = tick;
`endif
  end

  // Never drive while the core writes.
  assign data = (run && !rw) ? rd_val : 8'hzz;

endmodule

// File: tb/tb_u13_mem.sv
module tb_u13_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw = 1'b0;
  logic [7:0]  drv = 8'h00;
  logic        drv_en = 1'b0;
  wire  [7:0]  data;
  logic        cpu_rst;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic [7:0]  io_out;
  logic        io_stb;

  int total = 0;
  int bad = 0;

  logic [7:0] prog1 [7]  = '{8'ha9, 8'h05, 8'h69, 8'h03, 8'h85, 8'h80, 8'hea};
  logic [7:0] prog2 [16] = '{8'ha9, 8'h5a, 8'h85, 8'h10, 8'ha9, 8'h00, 8'ha5, 8'h10,
                             8'h69, 8'h00, 8'h85, 8'h80, 8'hea, 8'hea, 8'hea, 8'hea};

  assign data = drv_en ? drv : 8'hzz;

  always #5 clk = ~clk;

  u13_mem dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .rw       (rw),
    .data     (data),
    .cpu_rst  (cpu_rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .io_out   (io_out),
    .io_stb   (io_stb)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Bus must not carry the value the DUT would have driven.
  task automatic chk_nodrv(input string tag, input logic [7:0] obs, input logic [7:0] forbidden);
    total++;
    assert (obs !== forbidden) else begin
      bad++;
      $error("FAIL %s observed=%h expected=not-%h", tag, obs, forbidden);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // One core read cycle: present address, sample mid-cycle, advance.
  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr   = a;
    rw     = 1'b0;
    drv_en = 1'b0;
    #2;
    chk8(tag, data, exp);
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr   = a;
    rw     = 1'b1;
    drv    = d;
    drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    rw     = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk1("rst_cpu_rst", cpu_rst, 1'b1);
    chk1("rst_ld_ready", ld_ready, 1'b1);
    chk8("rst_io_out", io_out, 8'h00);
    chk1("rst_io_stb", io_stb, 1'b0);
    addr = 16'h1234;
    #1;
    chk_nodrv("load_no_drive", data, 8'hea);
    rst = 1'b1;
    step();

    // First program load, ld_last on the final byte
    for (int i = 0; i < 6; i++) load(prog1[i], 1'b0);
    chk1("load_ready_mid", ld_ready, 1'b1);
    load(prog1[6], 1'b1);
    chk1("release_ld_ready", ld_ready, 1'b0);
    chk1("release_cpu_rst", cpu_rst, 1'b1);
    addr = 16'hfff0;
    #1;
    chk_nodrv("release_no_drive", data, 8'ha9);
    step();
    chk1("run_cpu_rst", cpu_rst, 1'b0);

    // Tick counter: now in the 1st RUN cycle
    step();
    step();
    addr = 16'h0081;
    #1;
`ifdef U13_MEM_TICK_EN
    chk8("tick_3rd", data, 8'h02);
`else
    chk8("tick_absent", data, 8'hea);
`endif
    repeat (256) step();
`ifdef U13_MEM_TICK_EN
    chk8("tick_wrap", data, 8'h02);
`else
    chk8("tick_absent2", data, 8'hea);
`endif

    // Bus activity of LDA #5 / ADC #3 / STA $80
    for (int i = 0; i < 6; i++) rd_chk("fetch1", 16'hfff0 + 16'(i), prog1[i]);
    addr = 16'hfff0;
    rw   = 1'b1;
    #2;
    chk_nodrv("write_no_drive", data, 8'ha9);
    rw = 1'b0;
    wr(16'h0080, 8'h08);
    chk1("port_stb", io_stb, 1'b1);
    chk8("port_out", io_out, 8'h08);
    rd_chk("fetch_nop", 16'hfff6, 8'hea);
    chk1("port_stb_once", io_stb, 1'b0);
    rd_chk("unmapped", 16'h1234, 8'hea);
    rd_chk("io_read", 16'h0080, 8'hea);

    // Back-to-back port writes
    wr(16'h0080, 8'h11);
    chk1("b2b_stb1", io_stb, 1'b1);
    chk8("b2b_out1", io_out, 8'h11);
    wr(16'h0080, 8'h22);
    chk1("b2b_stb2", io_stb, 1'b1);
    chk8("b2b_out2", io_out, 8'h22);

    // ROM write protection
    wr(16'hfff3, 8'h77);
    chk1("rom_wr_no_stb", io_stb, 1'b0);
    rd_chk("rom_protect", 16'hfff3, 8'h03);

    // Loader ignored in RUN
    ld_valid = 1'b1;
    ld_data  = 8'h99;
    #1;
    chk1("run_ld_ready", ld_ready, 1'b0);
    step();
    ld_valid = 1'b0;
    addr = 16'hfff7;
    #1;
    chk_nodrv("run_ld_ignored", data, 8'h99);

    // Reset, partial load, mid-load reset
    rst = 1'b0;
    #1;
    chk1("rst2_cpu_rst", cpu_rst, 1'b1);
    chk1("rst2_ld_ready", ld_ready, 1'b1);
    chk8("rst2_io_out", io_out, 8'h00);
    rst = 1'b1;
    step();
    load(8'h11, 1'b0);
    load(8'h22, 1'b0);
    load(8'h33, 1'b0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();

    // 16 bytes without ld_last: auto-finish
    for (int i = 0; i < 15; i++) load(prog2[i], 1'b0);
    chk1("ovf_ready_15", ld_ready, 1'b1);
    load(prog2[15], 1'b0);
    chk1("ovf_ready_16", ld_ready, 1'b0);
    chk1("ovf_cpu_rst", cpu_rst, 1'b1);
    step();
    chk1("ovf_run", cpu_rst, 1'b0);

    // RAM round trip program bus activity
    rd_chk("rt_f0", 16'hfff0, 8'ha9);
    rd_chk("rt_f1", 16'hfff1, 8'h5a);
    rd_chk("rt_f2", 16'hfff2, 8'h85);
    rd_chk("rt_f3", 16'hfff3, 8'h10);
    wr(16'h0010, 8'h5a);
    rd_chk("rt_f4", 16'hfff4, 8'ha9);
    rd_chk("rt_f5", 16'hfff5, 8'h00);
    rd_chk("rt_f6", 16'hfff6, 8'ha5);
    rd_chk("rt_f7", 16'hfff7, 8'h10);
    rd_chk("rt_ram", 16'h0010, 8'h5a);
    rd_chk("rt_f8", 16'hfff8, 8'h69);
    rd_chk("rt_f9", 16'hfff9, 8'h00);
    rd_chk("rt_fa", 16'hfffa, 8'h85);
    rd_chk("rt_fb", 16'hfffb, 8'h80);
    wr(16'h0080, 8'h5a);
    chk1("rt_stb", io_stb, 1'b1);
    chk8("rt_io_out", io_out, 8'h5a);
    rd_chk("rom_last", 16'hffff, 8'hea);

    // No RAM mirrors, RAM top boundary
    wr(16'h0090, 8'h33);
    rd_chk("no_mirror", 16'h0010, 8'h5a);
    wr(16'h007f, 8'hc3);
    rd_chk("ram_top", 16'h007f, 8'hc3);
    rd_chk("above_ram", 16'h00ff, 8'hea);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u13_mem.md
Name: u13_mem

Overview:
- Memory and bus subsystem directly downstream of the u13 core. It answers the core's addr/data/rw bus and contains:
  - zero-page RAM;
  - a 16-byte loadable program ROM at the reset vector;
  - one memory-mapped output port.
- A byte-stream loader fills the ROM after reset while holding the core in reset, then releases the core to execute.

Parameters:
- RAM_AW, 7: RAM address width; RAM spans 0x0000..2^RAM_AW-1.
- ROM_AW, 4: ROM address width; ROM spans RST_ADDR..RST_ADDR+2^ROM_AW-1.
- RST_ADDR, 16'hfff0: ROM base, equal to the core reset vector.
- IO_ADDR, 16'h0080: output port address, reachable by zero-page STA.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- addr  in  16  core bus address.
- rw  in  1  core bus direction: 1 = core writes, 0 = core reads.
- data  inout  8  core bus data.
- cpu_rst  out  1  synchronous active-high reset to the core.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader ready.
- ld_data  in  8  loader byte.
- ld_last  in  1  final loader byte.
- io_out  out  8  output port value.
- io_stb  out  1  one-cycle pulse per port write.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, cpu_rst=1, ld_ready=1, io_out=0, io_stb=0, ld_cnt=0.
  - RAM and ROM contents are not reset.
- FSM LOAD -> RELEASE -> RUN:
  - LOAD:
    - Handshake: a byte transfers on a posedge with ld_valid&ld_ready. It is written to ROM[ld_cnt], then ld_cnt increments.
    - Leave LOAD for RELEASE on a transfer with ld_last=1, or on the transfer that writes ROM index 2^ROM_AW-1 (auto-finish; no wrap).
    - ld_ready=1 only in LOAD.
  - RELEASE: cpu_rst stays 1 for exactly one more cycle, so the core's synchronous reset loads pc=RST_ADDR. Then go to RUN.
  - RUN:
    - cpu_rst=0.
    - RUN is left only by rst; there is no reload path.
- Read path, RUN only:
  - Drive data combinationally when rw=0. This is zero-latency: the core samples data on the posedge after it registers addr.
  - RAM range returns RAM[addr]; ROM range returns ROM[addr-RST_ADDR].
  - IO_ADDR and unmapped addresses return 8'hea (NOP), so stray fetches execute as NOP.
- Drive gating:
  - When rw=1, or in LOAD/RELEASE, data is 8'hzz.
  - Never drive while rw=1, to avoid contention with the core.
- Write path, RUN only:
  - On a posedge with rw=1:
    - RAM range: RAM[addr]<=data.
    - IO_ADDR: io_out<=data and io_stb=1 for the next cycle only.
    - ROM range and unmapped: ignored.
  - Back-to-back port writes give back-to-back io_stb pulses.
- Loader bytes presented during RELEASE/RUN are not accepted (ld_ready=0).
- rst asserted mid-load discards progress: ld_cnt=0. ROM keeps partial contents, which are overwritten by the next load.
- Address decode uses the full 16 bits; RAM mirrors are not permitted.

Optional Feature:
- Macro: U13_MEM_TICK_EN.
- With the macro:
  - 8-bit tick counter, cleared on entry to RUN, incrementing every RUN cycle and wrapping 0xff->0x00.
  - Readable at IO_ADDR+1 (0x0081); writes there are ignored.
  - In LOAD/RELEASE the counter holds 0.
- Without the macro: 0x0081 is unmapped and reads 8'hea; no counter logic is present.

Decomposition:
- Package u13_pkg holds:
  - NOP opcode 8'hea;
  - default RST_ADDR;
  - state encodings LOAD/RELEASE/RUN;
  - the map constants (IO_ADDR, tick offset 1).
- One sub-module, u13_ram: parameterised width-8 array with synchronous write and asynchronous read. It is instantiated twice:
  - RAM, written from the core bus;
  - ROM, written from the loader only.

Test Plan:
- Reset and load:
  - Stimulus: rst low, then high. Stream a9 05 69 03 85 80 ea, ld_last on 0xea.
  - Required response: ld_ready drops after the last byte; cpu_rst stays high exactly one cycle after it; ROM[0..6] matches the stream.
- Run program from the first scenario: io_stb pulses once with io_out=0x08. Every fetch returns ROM data or 0xea; data is Z whenever rw=1.
- RAM round trip:
  - Stimulus: ROM a9 5a 85 10 a9 00 a5 10 69 00 85 80 (clear carry via reset).
  - Required response: io_out=0x5a.
- ROM write protection: core writes 0x77 to 0xfff3 via the bench driving the bus in RUN; a read of 0xfff3 afterwards still returns the loaded byte.
- Overflow and mid-load reset:
  - 16 bytes with no ld_last -> auto RELEASE after the 16th byte.
  - rst pulse after 3 bytes -> ld_cnt=0; the next byte lands at ROM[0].
- Tick counter, with U13_MEM_TICK_EN: read 0x0081 on the 3rd RUN cycle -> 0x02; after 256 more cycles the value is the same. Without the macro, the read returns 0xea.
